// File: rtl/note_sequencer.sv
// note_sequencer
// Step sequencer driving a single pulse_generator. A DEPTH-entry table holds
// {ticks, dur} steps; on start, each step's period is loaded into the
// generator and DUR generator pulses are counted before moving on. A dur of 0
// marks the end of the sequence, as does completing entry DEPTH-1. Playback
// either finishes (one-cycle done pulse) or restarts at step 0 when loop_en.
//
// Ports:
//   clk                     rising-edge clock
//   rst                     asynchronous active-low reset
//   wr_en/wr_addr/wr_ticks/wr_dur   table write port (any state)
//   start, stop, loop_en    playback control (stop has priority)
//   pg_out                  pulse from the generator
//   pg_ticks, pg_ena, pg_rst   generator period / enable / sync reset
//   busy, step_idx, done    status
module note_sequencer #(
  parameter  int N     = 8,
  parameter  int D     = 8,
  parameter  int DEPTH = 8,
  localparam int A     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [N-1:0] wr_ticks,
  input  logic [D-1:0] wr_dur,
  input  logic         start,
  input  logic         stop,
  input  logic         loop_en,
  input  logic         pg_out,
  output logic [N-1:0] pg_ticks,
  output logic         pg_ena,
  output logic         pg_rst,
  output logic         busy,
  output logic [A-1:0] step_idx,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [A-1:0]   idx_q, idx_d;
  logic [D-1:0]   cnt_q, cnt_d;
  logic [D-1:0]   dur_q, dur_d;
  logic [N-1:0]   pg_ticks_q, pg_ticks_d;

  // Step table: plain registers so the whole table clears on reset.
  logic [N-1:0]   tbl_ticks_q [DEPTH];
  logic [D-1:0]   tbl_dur_q   [DEPTH];
  logic [N-1:0]   tbl_ticks_d [DEPTH];
  logic [D-1:0]   tbl_dur_d   [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tbl_ticks_d[i] = tbl_ticks_q[i];
      tbl_dur_d[i]   = tbl_dur_q[i];
      if (wr_en && (wr_addr == A'(i))) begin
        tbl_ticks_d[i] = wr_ticks;
        tbl_dur_d[i]   = wr_dur;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tbl_ticks_q[gi] <= '0;
          tbl_dur_q[gi]   <= '0;
        end else begin
          tbl_ticks_q[gi] <= tbl_ticks_d[gi];
          tbl_dur_q[gi]   <= tbl_dur_d[gi];
        end
      end
    end
  endgenerate

  logic [N-1:0] rd_ticks;
  logic [D-1:0] rd_dur;
  logic [D-1:0] cnt_inc;
  logic         last_idx;

  // The table read in LOAD sees only writes committed at earlier edges.
  assign rd_ticks = tbl_ticks_q[idx_q];
  assign rd_dur   = tbl_dur_q[idx_q];
  assign cnt_inc  = cnt_q + D'(1);
  assign last_idx = (idx_q == A'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dur_d      = dur_q;
    pg_ticks_d = pg_ticks_q;

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (rd_dur != '0) begin
            // Latch period and length so table writes don't disturb this step.
            pg_ticks_d = rd_ticks;
            dur_d      = rd_dur;
            cnt_d      = '0;
            state_d    = S_RUN;
          end else if ((idx_q != '0) && loop_en) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
        S_RUN: begin
          if (pg_out) begin
            cnt_d = cnt_inc;
            if (cnt_inc == dur_q) begin
              if (!last_idx) begin
                idx_d   = idx_q + A'(1);
                state_d = S_LOAD;
              end else if (loop_en) begin
                // Wrapping after the last entry needs no dur==0 LOAD.
                idx_d   = '0;
                state_d = S_LOAD;
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      dur_q      <= '0;
      pg_ticks_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      dur_q      <= dur_d;
      pg_ticks_q <= pg_ticks_d;
    end
  end

  // Generator controls decode straight from state so reset reaches them at once.
  assign pg_ticks = pg_ticks_q;
  assign pg_ena   = (state_q == S_RUN);
  assign pg_rst   = (state_q != S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign step_idx = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_ticks;
  logic [7:0] wr_dur;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic       pg_out;
  logic [7:0] pg_ticks;
  logic       pg_ena;
  logic       pg_rst;
  logic       busy;
  logic [2:0] step_idx;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  note_sequencer #(.N(8), .D(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_ticks(wr_ticks), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop_en(loop_en), .pg_out(pg_out), .pg_ticks(pg_ticks),
    .pg_ena(pg_ena), .pg_rst(pg_rst), .busy(busy), .step_idx(step_idx),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pulse_generator: counter cleared by pg_rst, pulses at ==ticks.
  logic [7:0] gen_cnt = 8'd0;
  always @(posedge clk) begin
    if (pg_rst) gen_cnt <= 8'd0;
    else if (pg_ena) gen_cnt <= (gen_cnt == pg_ticks) ? 8'd0 : gen_cnt + 8'd1;
  end
  assign pg_out = pg_ena && (gen_cnt == pg_ticks);

  int pulse_cnt = 0;
  always @(posedge clk) if (pg_out) pulse_cnt <= pulse_cnt + 1;

  // Scoreboard of per-cycle expectations: {busy, ena, rst, done, idx, ticks}.
  typedef struct packed {logic [14:0] val; logic [14:0] mask;} exp_t;
  exp_t sb[$];
  int   sb_limit;
  logic [7:0] m_ticks [8];
  logic [7:0] m_dur   [8];

  function automatic void push_rec(bit b, bit e, bit r, bit d, logic [2:0] idx,
                                   logic [7:0] tk, bit chk_idx, bit chk_tk);
    exp_t x;
    x.val  = {b, e, r, d, idx, tk};
    x.mask = {4'hF, (chk_idx ? 3'h7 : 3'h0), (chk_tk ? 8'hFF : 8'h00)};
    if (sb.size() < sb_limit) sb.push_back(x);
  endfunction

  // Expected cycle trace from the step timing rules: cycle 0 is the start cycle.
  task automatic build_trace(input bit lp, input int limit);
    logic [2:0] idx;
    bit fin;
    int run_len;
    sb.delete();
    sb_limit = limit;
    idx = 3'd0;
    fin = 1'b0;
    push_rec(0, 0, 1, 0, 3'd0, 8'd0, 0, 0);
    while (!fin && sb.size() < limit) begin
      push_rec(1, 0, 1, 0, idx, 8'd0, 1, 0);
      if (m_dur[idx] == 8'd0) begin
        if (idx != 3'd0 && lp) idx = 3'd0;
        else fin = 1'b1;
      end else begin
        run_len = int'(m_dur[idx]) * (int'(m_ticks[idx]) + 1);
        for (int k = 0; k < run_len && sb.size() < limit; k++)
          push_rec(1, 1, 0, 0, idx, m_ticks[idx], 1, 1);
        if (idx != 3'd7) idx = idx + 3'd1;
        else if (lp) idx = 3'd0;
        else fin = 1'b1;
      end
    end
    if (fin) begin
      push_rec(1, 0, 1, 1, idx, 8'd0, 1, 0);
      while (sb.size() < limit) push_rec(0, 0, 1, 0, idx, 8'd0, 1, 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; wr_en = 0; start = 0; stop = 0; loop_en = 0;
    for (int i = 0; i < 8; i++) begin m_ticks[i] = 8'd0; m_dur[i] = 8'd0; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [7:0] t, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_ticks = t; wr_dur = d;
    m_ticks[a] = t; m_dur[a] = d;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_ticks = 0; wr_dur = 0;
    start = 0; stop = 0; loop_en = 0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (pg_ena !== 1'b0)   begin n_bad++; $display("FAIL reset_ena got=%b want=0", pg_ena); end
    n_cmp++; if (pg_rst !== 1'b1)   begin n_bad++; $display("FAIL reset_pgrst got=%b want=1", pg_rst); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (step_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx got=%0d want=0", step_idx); end
    n_cmp++; if (pg_ticks !== 8'd0) begin n_bad++; $display("FAIL reset_ticks got=%0d want=0", pg_ticks); end
    $display("test_reset: outputs checked under reset");
    do_reset();
  endtask

  task automatic test_basic();
    exp_t e; logic [14:0] obs; int p0;
    do_reset();
    write_entry(3'd0, 8'd3, 8'd2);
    write_entry(3'd1, 8'd1, 8'd3);
    build_trace(1'b0, 21);
    p0 = pulse_cnt;
    for (int c = 0; c < 21; c++) begin
      if (c == 0) start = 1;
      @(negedge clk);
      obs = {busy, pg_ena, pg_rst, done, step_idx, pg_ticks};
      e = sb.pop_front();
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++; $display("FAIL basic c=%0d got=%h want=%h mask=%h", c, obs, e.val, e.mask);
      end
      @(posedge clk); #1; start = 0;
    end
    n_cmp++;
    if (pulse_cnt - p0 !== 5) begin
      n_bad++; $display("FAIL basic_pulses got=%0d want=5", pulse_cnt - p0);
    end
    $display("test_basic: two-step sequence, %0d pulses", pulse_cnt - p0);
  endtask

  task automatic test_loop_stop();
    exp_t e; logic [14:0] obs;
    do_reset();
    write_entry(3'd0, 8'd3, 8'd2);
    write_entry(3'd1, 8'd1, 8'd3);
    loop_en = 1;
    build_trace(1'b1, 31);
    for (int c = 0; c < 31; c++) begin
      if (c == 0) start = 1;
      @(negedge clk);
      obs = {busy, pg_ena, pg_rst, done, step_idx, pg_ticks};
      e = sb.pop_front();
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++; $display("FAIL loop c=%0d got=%h want=%h mask=%h", c, obs, e.val, e.mask);
      end
      @(posedge clk); #1; start = 0;
    end
    // Cycle 31 is mid-RUN of step 1; stop here.
    stop = 1;
    @(posedge clk); #1; stop = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, pg_ena, pg_rst, done} !== 4'b0010) begin
        n_bad++; $display("FAIL loop_stop c=%0d got=%b want=0010", c, {busy, pg_ena, pg_rst, done});
      end
      @(posedge clk); #1;
    end
    loop_en = 0;
    $display("test_loop_stop: looping playback aborted by stop");
  endtask

  task automatic test_all_ones();
    exp_t e; logic [14:0] obs;
    do_reset();
    for (int i = 0; i < 8; i++) write_entry(3'(i), 8'd0, 8'd1);
    build_trace(1'b0, 20);
    for (int c = 0; c < 20; c++) begin
      if (c == 0) start = 1;
      @(negedge clk);
      obs = {busy, pg_ena, pg_rst, done, step_idx, pg_ticks};
      e = sb.pop_front();
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++; $display("FAIL all_ones c=%0d got=%h want=%h mask=%h", c, obs, e.val, e.mask);
      end
      @(posedge clk); #1; start = 0;
    end
    $display("test_all_ones: full table of single-cycle steps");
  endtask

  task automatic test_empty();
    exp_t e; logic [14:0] obs;
    do_reset();
    build_trace(1'b0, 5);
    for (int c = 0; c < 5; c++) begin
      if (c == 0) start = 1;
      @(negedge clk);
      obs = {busy, pg_ena, pg_rst, done, step_idx, pg_ticks};
      e = sb.pop_front();
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++; $display("FAIL empty c=%0d got=%h want=%h mask=%h", c, obs, e.val, e.mask);
      end
      @(posedge clk); #1; start = 0;
    end
    $display("test_empty: empty table completes immediately");
  endtask

  task automatic test_write_during_play();
    exp_t e; logic [14:0] obs;
    do_reset();
    write_entry(3'd0, 8'd2, 8'd4);
    loop_en = 1;
    sb.delete(); sb_limit = 23;
    push_rec(0, 0, 1, 0, 3'd0, 8'd0, 0, 0);
    push_rec(1, 0, 1, 0, 3'd0, 8'd0, 1, 0);
    for (int k = 0; k < 12; k++) push_rec(1, 1, 0, 0, 3'd0, 8'd2, 1, 1);
    push_rec(1, 0, 1, 0, 3'd1, 8'd0, 1, 0);
    push_rec(1, 0, 1, 0, 3'd0, 8'd0, 1, 0);
    for (int k = 0; k < 6; k++) push_rec(1, 1, 0, 0, 3'd0, 8'd5, 1, 1);
    push_rec(1, 0, 1, 0, 3'd1, 8'd0, 1, 0);
    for (int c = 0; c < 23; c++) begin
      if (c == 0) start = 1;
      if (c == 5) begin wr_en = 1; wr_addr = 3'd0; wr_ticks = 8'd5; wr_dur = 8'd1; end
      if (c == 6) wr_en = 0;
      @(negedge clk);
      obs = {busy, pg_ena, pg_rst, done, step_idx, pg_ticks};
      e = sb.pop_front();
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++; $display("FAIL wr_play c=%0d got=%h want=%h mask=%h", c, obs, e.val, e.mask);
      end
      @(posedge clk); #1; start = 0;
    end
    stop = 1;
    @(posedge clk); #1; stop = 0; loop_en = 0;
    $display("test_write_during_play: rewrite applies on next loop");
  endtask

  task automatic test_async_rst();
    exp_t e; logic [14:0] obs;
    do_reset();
    write_entry(3'd0, 8'd3, 8'd2);
    for (int c = 0; c < 5; c++) begin
      if (c == 0) start = 1;
      @(posedge clk); #1; start = 0;
    end
    n_cmp++;
    if (pg_ena !== 1'b1) begin n_bad++; $display("FAIL arst_pre got=%b want=1", pg_ena); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, pg_ena, pg_rst, done, step_idx, pg_ticks} !== {4'b0010, 3'd0, 8'd0}) begin
      n_bad++; $display("FAIL arst_outputs got=%h want=%h",
                        {busy, pg_ena, pg_rst, done, step_idx, pg_ticks}, {4'b0010, 3'd0, 8'd0});
    end
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 8; i++) begin m_ticks[i] = 8'd0; m_dur[i] = 8'd0; end
    // Table was cleared, so a start must behave as an empty sequence.
    build_trace(1'b0, 4);
    for (int c = 0; c < 4; c++) begin
      if (c == 0) start = 1;
      @(negedge clk);
      obs = {busy, pg_ena, pg_rst, done, step_idx, pg_ticks};
      e = sb.pop_front();
      n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++; $display("FAIL arst_tbl c=%0d got=%h want=%h mask=%h", c, obs, e.val, e.mask);
      end
      @(posedge clk); #1; start = 0;
    end
    $display("test_async_rst: reset mid-RUN clears state and table");
  endtask

  task automatic test_start_stop();
    write_entry(3'd0, 8'd1, 8'd2);
    start = 1; stop = 1;
    @(posedge clk); #1; start = 0; stop = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, pg_ena, pg_rst, done} !== 4'b0010) begin
        n_bad++; $display("FAIL start_stop c=%0d got=%b want=0010", c, {busy, pg_ena, pg_rst, done});
      end
      @(posedge clk); #1;
    end
    $display("test_start_stop: simultaneous start and stop stays idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_loop_stop();
    test_all_ones();
    test_empty();
    test_write_during_play();
    test_async_rst();
    test_start_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
